// File: rtl/stopwatch_controller_if.sv
// Stopwatch controller bundle: button and divider inputs, divider control and
// display outputs. The master side is whatever drives the buttons and divider
// clock. The slave side is the controller itself.
interface stopwatch_controller_if;
  logic       btn_ss;
  logic       btn_lr;
  logic       div_clk;
  logic       div_ena;
  logic       div_res;
  logic [3:0] min_t;
  logic [3:0] min_o;
  logic [3:0] sec_t;
  logic [3:0] sec_o;
  logic [3:0] tenth;
  logic       running;
  logic       lap_active;

  modport master (
    output btn_ss, btn_lr, div_clk,
    input  div_ena, div_res, min_t, min_o, sec_t, sec_o, tenth, running, lap_active
  );

  modport slave (
    input  btn_ss, btn_lr, div_clk,
    output div_ena, div_res, min_t, min_o, sec_t, sec_o, tenth, running, lap_active
  );
endinterface

// File: rtl/stopwatch_controller.sv
// Stopwatch sequencer for the 10 Hz timebase. It turns the start/stop and
// lap/reset button rises into IDLE/RUN/LAP/PAUSE transitions, gates and clears
// the external divider, and counts divider edges into a BCD MM:SS.t value. The
// display shows either the live time or the frozen lap capture.
module stopwatch_controller #(
  parameter int unsigned MAX_MIN = 60
) (
  input  logic                  clk_in,
  input  logic                  res,
  stopwatch_controller_if.slave sw
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_LAP   = 2'd2,
    S_PAUSE = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
    logic [3:0] tenth;
  } bcd_time_t;

  // Last minute value before the wrap to 00, split into BCD digits.
  localparam logic [3:0] MIN_T_LAST = 4'((MAX_MIN - 1) / 10);
  localparam logic [3:0] MIN_O_LAST = 4'((MAX_MIN - 1) % 10);

  state_e    state_q, state_d;
  bcd_time_t time_q, time_d;
  bcd_time_t lap_q, lap_d;
  logic      ss_prev_q, lr_prev_q, dclk_prev_q;

  logic ss_edge, lr_edge, tick, counting;

  assign ss_edge  = sw.btn_ss & ~ss_prev_q;
  assign lr_edge  = sw.btn_lr & ~lr_prev_q;
  assign tick     = sw.div_clk ^ dclk_prev_q;
  assign counting = (state_q == S_RUN) || (state_q == S_LAP);

  // One-tenth increment with the BCD carry chain and the minute wrap.
  function automatic bcd_time_t bcd_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.tenth != 4'd9) begin
      r.tenth = t.tenth + 4'd1;
    end else begin
      r.tenth = 4'd0;
      if (t.sec_o != 4'd9) begin
        r.sec_o = t.sec_o + 4'd1;
      end else begin
        r.sec_o = 4'd0;
        if (t.sec_t != 4'd5) begin
          r.sec_t = t.sec_t + 4'd1;
        end else begin
          r.sec_t = 4'd0;
          if (t.min_t == MIN_T_LAST && t.min_o == MIN_O_LAST) begin
            r.min_t = 4'd0;
            r.min_o = 4'd0;
          end else if (t.min_o == 4'd9) begin
            r.min_o = 4'd0;
            r.min_t = t.min_t + 4'd1;
          end else begin
            r.min_o = t.min_o + 4'd1;
          end
        end
      end
    end
    return r;
  endfunction

  // Next state, time and lap capture. The start/stop edge takes priority, so a
  // simultaneous lap/reset edge is discarded.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    state_d = state_q;
    time_d  = time_q;
    lap_d   = lap_q;

    // The count uses the current state. A tick on a leaving-RUN/LAP edge is
    // therefore kept, and a tick on the PAUSE -> RUN edge is dropped.
    if (counting && tick) begin
      time_d = bcd_inc(time_q);
    end

    unique case (state_q)
      S_IDLE: begin
        time_d = '0;
        if (ss_edge) state_d = S_RUN;
      end
      S_RUN: begin
        if (ss_edge) begin
          state_d = S_PAUSE;
        end else if (lr_edge) begin
          state_d = S_LAP;
          lap_d   = time_q;  // pre-increment value
        end
      end
      S_LAP: begin
        if (ss_edge)      state_d = S_PAUSE;
        else if (lr_edge) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (ss_edge) begin
          state_d = S_RUN;
        end else if (lr_edge) begin
          state_d = S_IDLE;
          time_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, time, lap and edge-detect registers with synchronous reset.
  // The button history resets high so a button held through reset does not fire.
  always_ff @(posedge clk_in) begin
    // NOTE: non-blocking assignments keep every register sampling the pre-edge
    // values, regardless of the statement order.
    if (res) begin
      state_q     <= S_IDLE;
      time_q      <= '0;
      lap_q       <= '0;
      ss_prev_q   <= 1'b1;
      lr_prev_q   <= 1'b1;
      dclk_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_q      <= time_d;
      lap_q       <= lap_d;
      ss_prev_q   <= sw.btn_ss;
      lr_prev_q   <= sw.btn_lr;
      dclk_prev_q <= sw.div_clk;
    end
  end

  bcd_time_t disp;
  assign disp = (state_q == S_LAP) ? lap_q : time_q;

  assign sw.running    = counting;
  assign sw.lap_active = (state_q == S_LAP);
  assign sw.div_ena    = counting;
  assign sw.div_res    = (state_q != S_IDLE);
  assign sw.min_t      = disp.min_t;
  assign sw.min_o      = disp.min_o;
  assign sw.sec_t      = disp.sec_t;
  assign sw.sec_o      = disp.sec_o;
  assign sw.tenth      = disp.tenth;

endmodule

// File: doc/stopwatch_controller.md
# stopwatch_controller

Sequencing controller for the 10 Hz timebase in the simple-clock design. It decodes the start/stop and lap/reset buttons into a four-state stopwatch FSM. It gates and clears the clock divider, and counts divider edges into a BCD MM:SS.t time value. It also drives the digits that the display path shows, either live or frozen for a lap.

## Interface

Parameters:
- MAX_MIN, default 60: minute modulus. Legal range 1..60. The counter wraps from (MAX_MIN-1):59.9 to 00:00.0.

Ports:
- clk_in  input  1  system clock (1 MHz)
- res  input  1  reset, synchronous, active-high
- btn_ss  input  1  start/stop button, already debounced and synchronous to clk_in
- btn_lr  input  1  lap/reset button, already debounced and synchronous to clk_in
- div_clk  input  1  divider output; each edge (rise or fall) marks one 100 ms tick
- div_ena  output  1  divider enable
- div_res  output  1  divider clear, active-low (0 = divider held cleared)
- min_t, min_o  output  4 each  minutes tens/ones, BCD
- sec_t, sec_o  output  4 each  seconds tens/ones, BCD
- tenth  output  4  tenths of a second, BCD
- running  output  1  high in RUN and LAP
- lap_active  output  1  high in LAP

## Operation

Input decoding:
- ss_edge = btn_ss & ~ss_prev. lr_edge = btn_lr & ~lr_prev.
- tick = div_clk ^ dclk_prev.
- All prev registers update every cycle.

FSM states and actions:
- IDLE: time = 0. div_ena=0, div_res=0.
  - ss_edge: go to RUN. lr_edge: ignored.
- RUN: div_ena=1, div_res=1. Display shows live time.
  - ss_edge: go to PAUSE.
  - lr_edge: go to LAP and capture live time into the lap registers on the same edge.
- LAP: counter keeps running. Display shows the lap registers.
  - lr_edge: go to RUN (display returns to live).
  - ss_edge: go to PAUSE (display returns to live).
- PAUSE: div_ena=0, div_res=1. The divider holds its phase, so the partial tenth is preserved.
  - ss_edge: go to RUN.
  - lr_edge: go to IDLE and clear time to 0.

Rules that apply in every state:
- Simultaneous ss_edge and lr_edge: ss_edge wins; lr_edge is discarded.
- Counting happens only in RUN and LAP, one increment per tick. Ticks in IDLE or PAUSE are ignored, but dclk_prev still tracks div_clk so resuming does not produce a spurious tick.
- Counter carry chain:
  - tenth 9 -> 0 carries into sec_o.
  - sec_o 9 -> 0 carries into sec_t.
  - sec_t 5 -> 0 carries into the minutes.
  - Minutes count 00..(MAX_MIN-1) in BCD, then wrap to 00.
  - Non-BCD digit values never appear.
- A tick and an FSM transition on the same cycle:
  - RUN -> PAUSE, LAP -> PAUSE, and RUN -> LAP: the tick is still counted. For RUN -> LAP, the captured lap value is the pre-increment time.
  - PAUSE -> RUN: the tick is not counted.

## Timing

- All outputs are registered and update on the clk_in edge where the triggering input is first sampled high (a rise, or a div_clk change). This is zero cycles of added latency beyond that edge.
- From IDLE, the divider is released on the RUN edge. The first tick arrives 100 ms later (div_clk 0->1), so tenth=1 at 100 ms ±1 cycle.
- Reset values:
  - State IDLE. All digit outputs 0.
  - div_ena=0, div_res=0, running=0, lap_active=0.
  - Lap registers 0.
  - ss_prev=1 and lr_prev=1, so a button held through reset does not fire on release.
  - dclk_prev=0.
- Reset asserted mid-count overrides every transition and tick on that cycle. The next cycle is IDLE with zeros.

## Test plan

- Basic run: reset, pulse btn_ss, toggle div_clk 25 times -> running=1, div_ena=1, div_res=1, display 00:02.5.
- Pause/resume: in RUN at 00:01.3, pulse btn_ss, toggle div_clk 10 times -> display stays 00:01.3 and div_ena=0. Pulse btn_ss again, then 1 toggle -> 00:01.4.
- Lap: at 00:04.7, pulse btn_lr, then 30 ticks -> display frozen at 00:04.7 with lap_active=1. Pulse btn_lr -> display 00:07.7 and lap_active=0.
- Clear and priority:
  - From PAUSE at 00:09.9, pulse btn_lr -> IDLE, all digits 0, div_res=0.
  - In RUN, raise both buttons in the same cycle -> PAUSE, not LAP.
- Wrap with MAX_MIN=2: preload by ticking to 01:59.9, one more tick -> 00:00.0. At 00:59.9 + 1 tick -> 01:00.0.
- Reset corner cases:
  - Hold btn_ss high through reset, then release reset -> stays IDLE.
  - Assert res in LAP at 00:03.2 with a simultaneous tick -> IDLE, all outputs 0.
